// File: rtl/conv_result_streamer_pkg.sv
// rtl/conv_result_streamer_pkg.sv - shared widths, counts and state encoding for the result streamer
package conv_result_streamer_pkg;

  localparam int WIDTH = 20;
  localparam int N     = 9;
  localparam int IDX_W = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

endpackage

// File: rtl/conv_result_streamer_if.sv
// rtl/conv_result_streamer_if.sv - nine-result load channel plus serial result stream
interface conv_result_streamer_if;
  import conv_result_streamer_pkg::*;

  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8;

  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] out_data;
  logic [IDX_W-1:0]        out_index;
  logic                    out_last;

  logic signed [WIDTH-1:0] max_value;
  logic [IDX_W-1:0]        max_index;
  logic                    done;

  modport master (
    output in_valid, in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8, out_ready,
    input  in_ready, out_valid, out_data, out_index, out_last, max_value, max_index, done
  );

  modport slave (
    input  in_valid, in_0, in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8, out_ready,
    output in_ready, out_valid, out_data, out_index, out_last, max_value, max_index, done
  );

endinterface

// File: rtl/conv_result_streamer_signed_max_tracker.sv
// rtl/conv_result_streamer_signed_max_tracker.sv - running signed maximum, committed on the last index
module signed_max_tracker
  import conv_result_streamer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic signed [WIDTH-1:0] value,
  input  logic [IDX_W-1:0]        index,
  output logic signed [WIDTH-1:0] max_value,
  output logic [IDX_W-1:0]        max_index
);

  logic signed [WIDTH-1:0] run_value, best_value;
  logic [IDX_W-1:0]        run_index, best_index;

  // Candidate winner: first element loads unconditionally, later ones only if strictly greater
  always_comb begin
    best_value = run_value;
    best_index = run_index;
    if (clear || (value > run_value)) begin
      best_value = value;
      best_index = index;
    end
  end

  // Running max follows every transfer; the visible result only moves on the last index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_value <= '0;
      run_index <= '0;
      max_value <= '0;
      max_index <= '0;
    end else if (en) begin
      run_value <= best_value;
      run_index <= best_index;
      if (index == IDX_W'(N - 1)) begin
        max_value <= best_value;
        max_index <= best_index;
      end
    end
  end

endmodule

// File: rtl/conv_result_streamer.sv
// rtl/conv_result_streamer.sv - captures nine filter results and streams them one per transfer
module conv_result_streamer
  import conv_result_streamer_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  conv_result_streamer_if.slave  bus
);

  logic [0:0]              state;
  logic [IDX_W-1:0]        idx, nxt_idx;
  logic signed [WIDTH-1:0] bank   [N];
  logic signed [WIDTH-1:0] in_vec [N];
  logic signed [WIDTH-1:0] data_q;
  logic                    last_q, done_q;
  logic                    xfer, final_xfer;
  logic signed [WIDTH-1:0] max_v;
  logic [IDX_W-1:0]        max_i;

  assign in_vec[0] = bus.in_0;
  assign in_vec[1] = bus.in_1;
  assign in_vec[2] = bus.in_2;
  assign in_vec[3] = bus.in_3;
  assign in_vec[4] = bus.in_4;
  assign in_vec[5] = bus.in_5;
  assign in_vec[6] = bus.in_6;
  assign in_vec[7] = bus.in_7;
  assign in_vec[8] = bus.in_8;

  assign xfer       = (state == SEND) && bus.out_ready;
  assign final_xfer = xfer && (idx == IDX_W'(N - 1));
  assign nxt_idx    = idx + 1'b1;

  // Load the bank only from IDLE so a set is never disturbed mid-stream; advance on each transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      data_q <= '0;
      last_q <= 1'b0;
      done_q <= 1'b0;
      for (int i = 0; i < N; i++) bank[i] <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N; i++) bank[i] <= in_vec[i];
            idx    <= '0;
            data_q <= in_vec[0];
            last_q <= 1'b0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (final_xfer) begin
            idx    <= '0;
            last_q <= 1'b0;
            done_q <= 1'b1;
            state  <= IDLE;
          end else if (xfer) begin
            idx    <= nxt_idx;
            data_q <= bank[nxt_idx];
            last_q <= (nxt_idx == IDX_W'(N - 1));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  signed_max_tracker u_max (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (idx == '0),
    .en        (xfer),
    .value     (data_q),
    .index     (idx),
    .max_value (max_v),
    .max_index (max_i)
  );

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == SEND);
  assign bus.out_data  = data_q;
  assign bus.out_index = idx;
  assign bus.out_last  = last_q;
  assign bus.max_value = max_v;
  assign bus.max_index = max_i;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_conv_result_streamer.sv
// tb/tb_conv_result_streamer.sv - randomized self-checking bench for conv_result_streamer
module tb_conv_result_streamer;
  import conv_result_streamer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_result_streamer_if bus ();

  conv_result_streamer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic signed [WIDTH-1:0] cur [N];
  longint exp_max     = 0;
  longint exp_max_idx = 0;

  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_inputs(input logic signed [WIDTH-1:0] v [N]);
    bus.in_0 = v[0]; bus.in_1 = v[1]; bus.in_2 = v[2];
    bus.in_3 = v[3]; bus.in_4 = v[4]; bus.in_5 = v[5];
    bus.in_6 = v[6]; bus.in_7 = v[7]; bus.in_8 = v[8];
  endtask

  // Maximum of the set: largest signed value, earliest position wins a tie
  task automatic model_max(output longint mv, output longint mi);
    mv = cur[0];
    mi = 0;
    for (int i = 1; i < N; i++) begin
      if (longint'(cur[i]) > mv) begin
        mv = cur[i];
        mi = i;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},  bus.in_ready, 1);
    check({tag, "_out_valid"}, bus.out_valid, 0);
    check({tag, "_out_data"},  bus.out_data, 0);
    check({tag, "_out_index"}, bus.out_index, 0);
    check({tag, "_out_last"},  bus.out_last, 0);
    check({tag, "_max_value"}, bus.max_value, 0);
    check({tag, "_max_index"}, bus.max_index, 0);
    check({tag, "_done"},      bus.done, 0);
  endtask

  // mode 0: ready always high, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic run_set(input int mode, input bit inject, input int abort_at);
    int k = 0;
    int cyc = 0;
    int ph = 0;
    longint mv, mi;
    logic signed [WIDTH-1:0] junk [N];
    model_max(mv, mi);
    while (!bus.in_ready && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("ready_before_load", bus.in_ready, 1);
    drive_inputs(cur);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    cyc = 0;
    while (k < N && cyc < 200) begin
      check("out_valid",  bus.out_valid, 1);
      check("in_ready",   bus.in_ready, 0);
      check("out_data",   bus.out_data, cur[k]);
      check("out_index",  bus.out_index, k);
      check("out_last",   bus.out_last, (k == N - 1));
      check("max_hold",   bus.max_value, exp_max);
      check("maxi_hold",  bus.max_index, exp_max_idx);
      check("done_low",   bus.done, 0);
      if (abort_at != 0 && k == abort_at) begin
        rst_n = 1'b0;
        #1;
        exp_max = 0;
        exp_max_idx = 0;
        check_reset_outputs("abort");
        return;
      end
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (ph % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
      if (inject && k == 4) begin
        for (int i = 0; i < N; i++) junk[i] = WIDTH'($urandom());
        drive_inputs(junk);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.out_ready) k++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("transfers", k, N);
    if (mode == 0) check("drain_cycles", cyc, N);
    exp_max = mv;
    exp_max_idx = mi;
    check("done_pulse",     bus.done, 1);
    check("idle_out_valid", bus.out_valid, 0);
    check("idle_in_ready",  bus.in_ready, 1);
    check("max_value",      bus.max_value, exp_max);
    check("max_index",      bus.max_index, exp_max_idx);
    @(posedge clk); #1;
    check("done_one_cycle", bus.done, 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) cur[i] = '0;
    drive_inputs(cur);

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_reset_outputs("after_reset");

    for (int i = 0; i < N; i++) cur[i] = WIDTH'(i * 10 - 40);
    run_set(0, 1'b0, 0);
    run_set(1, 1'b0, 0);

    for (int i = 0; i < N; i++) cur[i] = -WIDTH'(524288);
    cur[3] = -WIDTH'(5);
    cur[6] = -WIDTH'(5);
    run_set(2, 1'b0, 0);

    for (int i = 0; i < N; i++) cur[i] = WIDTH'($urandom());
    run_set(2, 1'b1, 0);

    for (int i = 0; i < N; i++) cur[i] = WIDTH'($urandom());
    run_set(0, 1'b0, 5);
    @(posedge clk); #1;
    check("abort_no_done", bus.done, 0);
    rst_n = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("abort_release_done", bus.done, 0);
    check_reset_outputs("post_abort");

    for (int s = 0; s < 8; s++) begin
      for (int i = 0; i < N; i++) begin
        if (s % 2 == 0) cur[i] = WIDTH'($urandom());
        else            cur[i] = WIDTH'(int'($urandom_range(0, 6)) - 3);
      end
      run_set(s % 3, (s == 5), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_result_streamer.md
# conv_result_streamer

Receiving end of the Level1 pixel filter's nine-output interface. Captures the nine signed 20-bit filter results (output_0..output_8) in one handshake and streams them out one per transfer over a valid/ready channel. While streaming, it tracks the signed maximum and its index for downstream classification. It sits between the combinational filter stage and the next level's serial input.

## Interface
Parameters:
- WIDTH, 20, bit width of each signed result
- N, 9, number of results per window (fixed 3x3)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  a full set of nine results is presented
- in_ready  output  1  block can accept a set (high only in IDLE)
- in_0 .. in_8  input  WIDTH each  signed results; in_k maps to filter output_k
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  signed result currently offered
- out_index  output  4  index 0..8 of out_data
- out_last  output  1  high with out_valid when out_index == 8
- max_value  output  WIDTH  signed maximum of the last completed set
- max_index  output  4  index of max_value
- done  output  1  one-cycle pulse after the last transfer of a set

## Operation
- States: IDLE, SEND.
- IDLE:
  - in_ready = 1 and out_valid = 0.
  - When in_valid is high, capture in_0..in_8 into a 9-entry register bank, clear idx to 0, and go to SEND.
- SEND:
  - in_ready = 0, out_valid = 1, out_data = bank[idx], out_index = idx.
  - A transfer occurs on a cycle with out_valid && out_ready. On a transfer with idx < 8, increment idx.
  - On a transfer with idx == 8, return to IDLE and pulse done on the following cycle.
  - out_data and out_index hold stable while out_ready is low. Validity is never withdrawn.
- in_valid asserted during SEND is ignored. The bank is never overwritten mid-stream.
- Running max:
  - On the idx 0 transfer, the running max is loaded with that value unconditionally.
  - On each later transfer, it updates when the value is strictly greater by signed comparison. Ties keep the lowest index.
  - max_value/max_index commit on the final transfer and hold until the next set's final transfer.
- Arithmetic: all comparisons are signed WIDTH-bit. There is no widening and no saturation.

## Timing
- Reset (rst_n low, asynchronous) gives:
  - state = IDLE, idx = 0, bank = 0
  - in_ready = 1, out_valid = 0, out_data = 0, out_index = 0, out_last = 0
  - max_value = 0, max_index = 0, done = 0
- Capture latency: in_valid sampled high in IDLE at edge T gives out_valid = 1 from T+1.
- With out_ready tied high, a set drains in 9 cycles (T+1..T+9). done is high during T+10 and in_ready is high from T+10. The minimum set period is 10 cycles.
- Registered outputs: out_valid, out_data, out_index, out_last, max_value, max_index, done.
- in_ready is decoded from state.
- Reset mid-stream abandons the set immediately. No done pulse is produced and max_* return to 0.
- If in_valid is high in the cycle done pulses, the new set is accepted (state is IDLE).

## Structure
- Shared package holds:
  - WIDTH, N
  - IDX_W = 4
  - state encoding: IDLE = 1'b0, SEND = 1'b1
- The same package is used by the Level1 filter bench.
- One sub-module is natural: signed_max_tracker (clk, rst_n, clear, en, value, index → max_value, max_index).
- The bank, idx counter and FSM stay in the top module.

## Test plan
- Reset then idle: hold rst_n low 3 cycles, then release → in_ready = 1, out_valid = 0, all data outputs 0, done = 0.
- Full-rate drain:
  - Stimulus: in_k = k*10 - 40 (-40..40), out_ready = 1.
  - Response: out_data sequence -40,-30,...,40 on cycles T+1..T+9, out_last only at index 8.
  - Response: done at T+10, max_value = 40, max_index = 8.
- Backpressure:
  - Stimulus: same set, out_ready toggling 1,0,0,1,...
  - Response: out_data/out_index stable during stall cycles, no value lost or duplicated, exactly 9 transfers.
- Negative and tie handling:
  - Stimulus: all inputs -524288 except in_3 = in_6 = -5.
  - Response: max_value = -5, max_index = 3.
- Ignored load: in_valid pulsed with different data at index 4 of a stream → the stream continues with the original bank values and in_ready stays 0.
- Reset mid-stream: assert rst_n low after the 5th transfer → outputs return to reset values immediately with no done pulse. A new set then loads and drains correctly.
